// File: rtl/sram_1r1w_mask_model.sv
// 1R1W SRAM model with per-segment write mask, a power-on zeroing sweep and a 1- or 2-cycle read pipeline.
// Define SRAM_COLLISION_BYPASS_EN to forward same-cycle write data into a same-address read.
module sram_1r1w_mask_model #(
  parameter int Bits         = 32,
  parameter int Word_Depth   = 64,
  parameter int Add_Width    = 6,
  parameter int Seg_Num      = 4,
  parameter int Read_Latency = 1
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  input  logic                 RCEB,
  input  logic [Add_Width-1:0] RA,
  output logic [Bits-1:0]      Q,
  output logic                 RVALID,
  input  logic                 WCEB,
  input  logic [Add_Width-1:0] WA,
  input  logic [Bits-1:0]      D,
  input  logic [Seg_Num-1:0]   BWEB,
  output logic                 INIT_DONE
);
  localparam int SegW = Bits / Seg_Num;
  localparam logic [Add_Width-1:0] LastAddr = Add_Width'(Word_Depth - 1);
  localparam logic [Add_Width:0]   DepthW   = (Add_Width + 1)'(Word_Depth);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                          state_q, state_d;
  logic [Add_Width-1:0]            ptr_q, ptr_d;
  logic [Bits-1:0]                 mem_q [Word_Depth];
  logic [Read_Latency:1]           vld_pipe_q, vld_pipe_d;
  logic [Read_Latency:1][Bits-1:0] dat_pipe_q, dat_pipe_d;

  logic            run, ra_ok, wa_ok, rd_fire, wr_fire;
  logic [Bits-1:0] rd_raw, rd_data, wr_merge;

  assign run     = (state_q == ST_RUN);
  assign ra_ok   = {1'b0, RA} < DepthW;
  assign wa_ok   = {1'b0, WA} < DepthW;
  assign rd_fire = run && !RCEB;
  assign wr_fire = run && !WCEB && wa_ok;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == LastAddr) begin
        state_d = ST_RUN;
        ptr_d   = '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Masked segments take the current stored word so a single full-word write suffices.
  always_comb begin
    wr_merge = '0;
    for (int s = 0; s < Seg_Num; s++)
      wr_merge[s*SegW +: SegW] = BWEB[s] ? mem_q[WA][s*SegW +: SegW] : D[s*SegW +: SegW];
  end

  always_comb begin
    rd_raw = '0;
    if (ra_ok) rd_raw = mem_q[RA];
  end

`ifdef SRAM_COLLISION_BYPASS_EN
  assign rd_data = (ra_ok && wr_fire && (WA == RA)) ? wr_merge : rd_raw;
`else
  assign rd_data = rd_raw;
`endif

  // Array has no reset; contents are only cleared by the sweep.
  always_ff @(posedge CLK) begin
    if (state_q == ST_INIT) mem_q[ptr_q] <= '0;
    else if (wr_fire)       mem_q[WA]    <= wr_merge;
  end

  // Data stages only load on valid, so Q keeps the last delivered word.
  always_comb begin
    vld_pipe_d    = '0;
    dat_pipe_d    = dat_pipe_q;
    vld_pipe_d[1] = rd_fire;
    if (rd_fire) dat_pipe_d[1] = rd_data;
    for (int k = 2; k <= Read_Latency; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      if (vld_pipe_q[k-1]) dat_pipe_d[k] = dat_pipe_q[k-1];
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      dat_pipe_q <= dat_pipe_d;
    end
  end

  assign Q         = dat_pipe_q[Read_Latency];
  assign RVALID    = vld_pipe_q[Read_Latency];
  assign INIT_DONE = run;
endmodule
